// File: rtl/alu_uart_ctrl.sv
// Frame sequencer between a UART receiver/transmitter pair and a combinational ALU.
// It collects A, B and an opcode byte, holds them on the ALU inputs and sends the result back.
//
// state     | meaning
// WAIT_A    | idle; the next byte is operand A (no timeout)
// WAIT_B    | the next byte is operand B; inter-byte timeout armed
// WAIT_OP   | the next byte is the opcode; inter-byte timeout armed
// EXEC      | one cycle; capture the ALU result into tx_data
// SEND      | one cycle; tx_start is high
// WAIT_TX   | waiting for tx_done from the transmitter (no timeout)

module alu_uart_ctrl #(
   parameter int DATA_LENGTH    = 8,
   parameter int OP_LENGTH      = 6,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   rx_done,
   input  logic [DATA_LENGTH-1:0] rx_data,
   input  logic                   tx_done,
   output logic [DATA_LENGTH-1:0] A,
   output logic [DATA_LENGTH-1:0] B,
   output logic [OP_LENGTH-1:0]   Op_code,
   input  logic [DATA_LENGTH-1:0] Resultado,
   output logic                   tx_start,
   output logic [DATA_LENGTH-1:0] tx_data,
   output logic                   busy,
   output logic                   frame_err,
   output logic                   rx_overrun
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_EXEC, S_SEND, S_WAIT_TX
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             cap_a, cap_b, cap_op, cap_tx;
   logic             timeout, overrun;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_WAIT_A;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      cap_a     = 1'b0;
      cap_b     = 1'b0;
      cap_op    = 1'b0;
      cap_tx    = 1'b0;
      timeout   = 1'b0;
      overrun   = 1'b0;
      case (state)
         S_WAIT_A: begin
            if (rx_done) begin
               cap_a     = 1'b1;
               state_nxt = S_WAIT_B;
            end
         end
         S_WAIT_B, S_WAIT_OP: begin
            // an arriving byte wins over a simultaneous expiry
            if (rx_done) begin
               cap_b     = (state == S_WAIT_B);
               cap_op    = (state == S_WAIT_OP);
               state_nxt = (state == S_WAIT_B) ? S_WAIT_OP : S_EXEC;
            end else if (cnt == CNT_LAST) begin
               timeout   = 1'b1;
               state_nxt = S_WAIT_A;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_EXEC: begin
            cap_tx    = 1'b1;
            overrun   = rx_done;
            state_nxt = S_SEND;
         end
         S_SEND: begin
            overrun   = rx_done;
            state_nxt = S_WAIT_TX;
         end
         S_WAIT_TX: begin
            overrun = rx_done;
            if (tx_done) state_nxt = S_WAIT_A;
         end
         default: state_nxt = S_WAIT_A;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         A          <= '0;
         B          <= '0;
         Op_code    <= '0;
         tx_data    <= '0;
         tx_start   <= 1'b0;
         busy       <= 1'b0;
         frame_err  <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (cap_a)  A       <= rx_data;
         if (cap_b)  B       <= rx_data;
         if (cap_op) Op_code <= rx_data[OP_LENGTH-1:0];
         if (cap_tx) tx_data <= Resultado;
         tx_start   <= (state_nxt == S_SEND);
         busy       <= (state_nxt == S_EXEC) || (state_nxt == S_SEND) || (state_nxt == S_WAIT_TX);
         frame_err  <= timeout;
         rx_overrun <= overrun;
      end
   end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Randomized bench for alu_uart_ctrl: a frame-level model predicts operands, results,
// timeout discards and overruns from byte arrival times.

module tb_alu_uart_ctrl;

   localparam int T = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx_done = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       tx_done = 1'b0;
   logic [7:0] alu_a, alu_b, resultado, tx_data;
   logic [5:0] op_code;
   logic       tx_start, busy, frame_err, rx_overrun;

   alu_uart_ctrl #(.DATA_LENGTH(8), .OP_LENGTH(6), .TIMEOUT_CYCLES(T)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx_done    (rx_done),
      .rx_data    (rx_data),
      .tx_done    (tx_done),
      .A          (alu_a),
      .B          (alu_b),
      .Op_code    (op_code),
      .Resultado  (resultado),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .busy       (busy),
      .frame_err  (frame_err),
      .rx_overrun (rx_overrun)
   );

   always #5 clk = ~clk;

   // Stand-in for the external combinational ALU
   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      case (op)
         6'h20: return a + b;
         6'h22: return a - b;
         6'h24: return a & b;
         6'h25: return a | b;
         6'h26: return a ^ b;
         6'h27: return ~(a | b);
         6'h02: return a >> b;
         6'h03: return 8'($signed(a) >>> b);
         default: return 8'h00;
      endcase
   endfunction

   assign resultado = alu_ref(alu_a, alu_b, op_code);

   int cyc = 0;
   int fe_cnt = 0, ov_cnt = 0, ts_cnt = 0, ts_cyc = 0;
   logic [7:0] ts_data = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (frame_err)  fe_cnt <= fe_cnt + 1;
      if (rx_overrun) ov_cnt <= ov_cnt + 1;
   end

   always @(negedge clk) begin
      if (tx_start) begin
         ts_cnt  <= ts_cnt + 1;
         ts_cyc  <= cyc;
         ts_data <= tx_data;
      end
   end

   int n_chk = 0, n_pass = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // frame-level model
   int         pos = 0, last_e = 0, fe_exp = 0, ov_exp = 0, ts_exp = 0;
   logic [7:0] m_a = 8'h00, m_b = 8'h00;
   logic [5:0] m_op = 6'h00;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // a partial frame is dropped once T edges pass after its last byte without a new one
   task automatic resolve(input int now);
      if (pos != 0 && now - last_e >= T) begin
         pos = 0;
         fe_exp++;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int e;
      for (int i = 0; i < gap; i++) begin
         tx_done = ($urandom_range(0, 5) == 0);
         tick();
      end
      tx_done = 1'b0;
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      e = cyc;
      resolve(e - 1);
      case (pos)
         0: m_a = b;
         1: m_b = b;
         default: m_op = b[5:0];
      endcase
      pos++;
      last_e = e;
      check_val("frame_err_count", 64'(fe_cnt), 64'(fe_exp));
      check_val("operands", {40'h0, alu_a, alu_b, 2'b00, op_code}, {40'h0, m_a, m_b, 2'b00, m_op});
   endtask

   task automatic finish_frame(input bit ovr_exec, input bit ovr_wait, input int hold, output logic [7:0] got);
      int         e0;
      logic [7:0] exp;
      e0  = last_e;
      exp = alu_ref(m_a, m_b, m_op);
      check_val("busy_after_op", 64'(busy), 64'd1);
      check_val("tx_start_early", 64'(tx_start), 64'd0);
      if (ovr_exec) begin
         rx_data = 8'($urandom);
         rx_done = 1'b1;
         tick();
         rx_done = 1'b0;
         ov_exp++;
      end else begin
         tick();
      end
      tick();
      tick();
      ts_exp++;
      check_val("tx_start_count", 64'(ts_cnt), 64'(ts_exp));
      check_val("tx_start_cycle", 64'(ts_cyc), 64'(e0 + 1));
      check_val("tx_data_at_start", 64'(ts_data), 64'(exp));
      if (ovr_wait) begin
         rx_data = 8'h55;
         rx_done = 1'b1;
         tick();
         rx_done = 1'b0;
         ov_exp++;
      end
      for (int i = 0; i < hold; i++) tick();
      check_val("busy_wait_tx", 64'(busy), 64'd1);
      check_val("tx_data_stable", 64'(tx_data), 64'(exp));
      check_val("operands_held", {40'h0, alu_a, alu_b, 2'b00, op_code}, {40'h0, m_a, m_b, 2'b00, m_op});
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check_val("busy_fall", 64'(busy), 64'd0);
      check_val("overrun_count", 64'(ov_cnt), 64'(ov_exp));
      pos = 0;
      got = tx_data;
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input bit ovr_wait, output logic [7:0] got);
      send_byte(a, 0);
      send_byte(b, 1);
      send_byte(op, 2);
      finish_frame(1'b0, ovr_wait, 2, got);
   endtask

   task automatic async_reset(input string tag);
      #2;
      reset_n = 1'b0;
      #1;
      check_val(tag, {28'h0, alu_a, alu_b, 2'b00, op_code, tx_data, tx_start, busy, frame_err, rx_overrun}, 64'h0);
      tick();
      reset_n = 1'b1;
      pos = 0;
      m_a = 8'h00;
      m_b = 8'h00;
      m_op = 6'h00;
   endtask

   function automatic int rand_gap();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6)  return int'($urandom_range(0, 3));
      if (r == 6) return T - 1;
      if (r == 7) return T;
      if (r == 8) return T + 3;
      return 1;
   endfunction

   logic [7:0] got;
   int         fe_before, guard;
   logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};

   initial begin
      tick();
      tick();
      check_val("reset_state", {28'h0, alu_a, alu_b, 2'b00, op_code, tx_data, tx_start, busy, frame_err, rx_overrun}, 64'h0);
      reset_n = 1'b1;
      tick();

      run_frame(8'h05, 8'h03, 8'h20, 1'b0, got);
      check_val("add", 64'(got), 64'h08);
      run_frame(8'h03, 8'h05, 8'h22, 1'b0, got);
      check_val("sub", 64'(got), 64'hFE);
      run_frame(8'h80, 8'h02, 8'h03, 1'b0, got);
      check_val("sra", 64'(got), 64'hE0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'hE0, 0);
      check_val("op_mask", 64'(op_code), 64'h20);
      finish_frame(1'b0, 1'b0, 1, got);
      check_val("masked_add", 64'(got), 64'h33);
      run_frame(8'h11, 8'h22, 8'h3F, 1'b0, got);
      check_val("undef_op", 64'(got), 64'h00);

      fe_before = fe_cnt;
      send_byte(8'h07, 0);
      for (int i = 0; i < T + 1; i++) tick();
      resolve(cyc);
      check_val("timeout_pulse", 64'(fe_cnt - fe_before), 64'd1);
      check_val("timeout_keep_a", 64'(alu_a), 64'h07);
      check_val("timeout_idle", 64'(busy), 64'd0);
      run_frame(8'h01, 8'h01, 8'h20, 1'b0, got);
      check_val("after_timeout", 64'(got), 64'h02);

      fe_before = fe_cnt;
      send_byte(8'h09, 0);
      send_byte(8'h04, T - 1);
      send_byte(8'h20, T - 1);
      check_val("expiry_accept", 64'(fe_cnt - fe_before), 64'd0);
      finish_frame(1'b0, 1'b0, 0, got);
      check_val("expiry_frame", 64'(got), 64'h0D);

      run_frame(8'h40, 8'h0F, 8'h24, 1'b1, got);
      check_val("overrun_frame", 64'(got), 64'h00);
      run_frame(8'h06, 8'h02, 8'h22, 1'b0, got);
      check_val("post_overrun", 64'(got), 64'h04);

      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'h20, 0);
      tick();
      tick();
      tick();
      ts_exp++;
      async_reset("reset_wait_tx");
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      async_reset("reset_wait_op");
      run_frame(8'h0F, 8'hF0, 8'h25, 1'b0, got);
      check_val("after_reset", 64'(got), 64'hFF);

      for (int f = 0; f < 40; f++) begin
         guard = 0;
         while (pos < 3 && guard < 50) begin
            if (pos == 2)
               send_byte(($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, 7)], rand_gap());
            else
               send_byte(8'($urandom), rand_gap());
            guard++;
         end
         check_val("frame_complete", 64'(pos), 64'd3);
         if (pos != 3) break;
         finish_frame(1'($urandom), 1'($urandom), int'($urandom_range(0, 4)), got);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
